// File: rtl/disp_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits that share one
// BCD decoder: walks the digits in order, with a blanking guard at each slot change.
module disp_scan_ctrl #(
    parameter  int N_DIG        = 4,
    parameter  int PRESCALE     = 50000,
    parameter  int BLANK_CYCLES = 2,
    localparam int IW           = $clog2(N_DIG),
    localparam int CW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [N_DIG-1:0] dp_mask,
    input  logic             lz_blank,
    output logic [3:0]       bcd_out,
    output logic [N_DIG-1:0] an_n,
    output logic             dp_n,
    output logic [IW-1:0]    digit_idx,
    output logic             frame_tick
);

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } state_t;

    localparam state_t RST_STATE =
        (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST =
        (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);
    localparam logic [IW:0]   N_LIM    = (IW + 1)'(N_DIG);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       digit_q [N_DIG];
    logic [3:0]       digit_d [N_DIG];
    logic [N_DIG-1:0] an_q, an_d;
    logic             dp_q, dp_d;
    logic [N_DIG-1:0] sup_d;
    logic             zero_above;
    logic             slot_end;

    assign slot_end = (state_q == S_SHOW) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (en) begin
            unique case (state_q)
                S_BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (slot_end) begin
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                        state_d = RST_STATE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
    end

    always_comb begin
        digit_d = digit_q;
        if (wr_en && ({1'b0, wr_addr} < N_LIM)) begin
            digit_d[wr_addr] = wr_data;
        end
    end

    // Suppression looks at the post-write digits so an_n matches bcd_out.
    always_comb begin
        sup_d      = '0;
        zero_above = 1'b1;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            zero_above = zero_above && (digit_d[i] == 4'd0);
            sup_d[i]   = lz_blank && zero_above;
        end
    end

    always_comb begin
        an_d = '1;
        dp_d = 1'b1;
        if (en && (state_d == S_SHOW) && !sup_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            dp_d        = ~dp_mask[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            dp_q    <= 1'b1;
            for (int i = 0; i < N_DIG; i++) begin
                digit_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            for (int i = 0; i < N_DIG; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign bcd_out    = digit_q[idx_q];
    assign digit_idx  = idx_q;
    assign an_n       = an_q;
    assign dp_n       = dp_q;
    assign frame_tick = en && slot_end && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: per-cycle scoreboard against a slot-level model,
// plus spot checks of the timeline points called out for the block.
module tb_disp_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] dp_mask;
    logic       lz_blank;
    logic [3:0] bcd_out;
    logic [3:0] an_n;
    logic       dp_n;
    logic [1:0] digit_idx;
    logic       frame_tick;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .N_DIG(N),
        .PRESCALE(P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .dp_mask(dp_mask),
        .lz_blank(lz_blank),
        .bcd_out(bcd_out),
        .an_n(an_n),
        .dp_n(dp_n),
        .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         m_cnt;
    int         m_idx;
    logic [3:0] m_dig [N];
    logic [11:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [3:0] an;
        logic       dp;
        logic       ft;
        logic [3:0] sup;
        bit         zero;
        an   = 4'hF;
        dp   = 1'b1;
        sup  = 4'b0;
        zero = 1'b1;
        for (int i = N - 1; i >= 1; i--) begin
            zero   = zero && (m_dig[i] == 4'd0);
            sup[i] = lz_blank && zero;
        end
        if (rst_n && en && m_cnt >= B && !sup[m_idx]) begin
            an[m_idx] = 1'b0;
            dp        = ~dp_mask[m_idx];
        end
        ft = rst_n && en && (m_cnt == P - 1) && (m_idx == N - 1);
        return {an, dp, m_dig[m_idx], 2'(m_idx), ft};
    endfunction

    task automatic step();
        logic [11:0] e;
        if (!rst_n) begin
            m_cnt = 0;
            m_idx = 0;
            for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
        end else begin
            if (wr_en && wr_addr < N) m_dig[wr_addr] = wr_data;
            if (en) begin
                if (m_cnt == P - 1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % N;
                end else begin
                    m_cnt++;
                end
            end
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        cyc = rst_n ? cyc + 1 : 0;
        e = exp_q.pop_front();
        chk("cyc", 32'({an_n, dp_n, bcd_out, digit_idx, frame_tick}), 32'(e));
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        dp_mask  = '0;
        lz_blank = 1'b0;
        m_cnt    = 0;
        m_idx    = 0;
        for (int i = 0; i < N; i++) m_dig[i] = 4'd0;

        run(3);
        chk("rst_an", 32'(an_n), 32'hF);
        chk("rst_dp", 32'(dp_n), 32'h1);
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        write(2'd3, 4'd4);
        chk("blank1_an", 32'(an_n), 32'hF);
        write(2'd2, 4'd3);
        chk("show0_an", 32'(an_n), 32'hE);
        write(2'd1, 4'd2);
        write(2'd0, 4'd1);
        chk("show0_bcd", 32'(bcd_out), 32'h1);
        for (int k = 0; k < 36; k++) begin
            step();
            if (cyc == 10) chk("show1_an", 32'(an_n), 32'hD);
            if (cyc == 26) chk("show3_bcd", 32'(bcd_out), 32'h4);
            if (cyc == 30) chk("ft30", 32'(frame_tick), 32'h0);
            if (cyc == 31) chk("ft31", 32'(frame_tick), 32'h1);
            if (cyc == 32) chk("wrap_idx", 32'(digit_idx), 32'h0);
        end

        write(2'd3, 4'd0);
        write(2'd2, 4'd0);
        write(2'd1, 4'd5);
        write(2'd0, 4'd0);
        lz_blank = 1'b1;
        for (int k = 0; k < 64 && !(m_idx == 2 && m_cnt == 4); k++) step();
        chk("lz_sup2", 32'(an_n), 32'hF);
        run(32);
        lz_blank = 1'b0;
        for (int k = 0; k < 64 && !(m_idx == 3 && m_cnt == 4); k++) step();
        chk("lz_off3", 32'(an_n), 32'h7);
        run(16);

        dp_mask = 4'b0010;
        for (int k = 0; k < 64 && !(m_idx == 1 && m_cnt == 3); k++) step();
        chk("dp1", 32'(dp_n), 32'h0);
        write(2'd1, 4'd9);
        chk("midwr_bcd", 32'(bcd_out), 32'h9);
        chk("midwr_an", 32'(an_n), 32'hD);
        run(24);

        for (int k = 0; k < 64 && !(m_idx == 2 && m_cnt == 5); k++) step();
        en = 1'b0;
        run(4);
        write(2'd0, 4'd6);
        run(5);
        chk("pause_an", 32'(an_n), 32'hF);
        chk("pause_idx", 32'(digit_idx), 32'h2);
        en = 1'b1;
        run(20);

        for (int k = 0; k < 64 && !(m_idx == 3 && m_cnt == 4); k++) step();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 4'd7;
        step();
        wr_en = 1'b0;
        chk("mrst_idx", 32'(digit_idx), 32'h0);
        chk("mrst_an", 32'(an_n), 32'hF);
        chk("mrst_bcd", 32'(bcd_out), 32'h0);
        rst_n = 1'b1;
        run(P * N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-7-segment decoder.
- Holds a writable digit register file and drives the currently scanned nibble to the shared decoder's BCD input.
- Drives active-low digit enables, inserting a blanking guard at every slot change to suppress ghosting.
- Sits between system logic, which writes digit values, and the display pins.

Parameters:
N_DIG, 4, number of digits scanned (2..8); digit 0 = least significant.
PRESCALE, 50000, clocks per digit slot (blank + show); must satisfy PRESCALE > BLANK_CYCLES.
BLANK_CYCLES, 2, clocks per slot with all digits off (0 = no blanking).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
en  in  1  scan enable; 0 freezes scan and blanks display.
wr_en  in  1  digit write strobe.
wr_addr  in  clog2(N_DIG)  digit index to write; values >= N_DIG ignored.
wr_data  in  4  BCD/hex value for digit.
dp_mask  in  N_DIG  decimal point request per digit, 1 = lit.
lz_blank  in  1  leading-zero suppression enable.
bcd_out  out  4  nibble to shared decoder = digit_reg[idx].
an_n  out  N_DIG  digit enables, active-low, one-cold or all-high.
dp_n  out  1  decimal point segment, active-low.
digit_idx  out  clog2(N_DIG)  index of current slot.
frame_tick  out  1  one-cycle pulse per full scan.

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset state: all digit_reg = 0, idx = 0, cnt = 0, state BLANK; an_n all 1, dp_n = 1, frame_tick = 0, bcd_out = 0.
- Reset asserted mid-scan behaves the same: everything returns to the reset state on the next edge, and pending writes in that cycle are dropped.
- FSM, two states:
  - BLANK: an_n all 1, dp_n = 1, runs BLANK_CYCLES clocks; skipped entirely when BLANK_CYCLES = 0.
  - SHOW: runs PRESCALE - BLANK_CYCLES clocks; an_n[idx] = 0 unless the digit is suppressed; dp_n = ~dp_mask[idx] unless the digit is suppressed.
- cnt counts 0..PRESCALE-1 across the slot. On the last SHOW cycle, idx <= (idx == N_DIG-1) ? 0 : idx+1, cnt <= 0, state <= BLANK.
- Scan order: 0, 1, ..., N_DIG-1, then wrap to 0.
- frame_tick = 1 exactly during the last SHOW cycle of idx = N_DIG-1; 0 otherwise.
- bcd_out and digit_idx follow idx with zero latency (decoded from flops). They change at the slot boundary, i.e. while an_n is still blanked when BLANK_CYCLES >= 1.
- an_n and dp_n are registered outputs derived from state/idx.
- Writes: on an edge with wr_en = 1 and wr_addr < N_DIG, digit_reg[wr_addr] <= wr_data. A write to the digit currently shown appears on bcd_out the next cycle without disturbing scan timing. Writes are accepted regardless of en.
- Leading-zero suppression (lz_blank = 1): digit i (i >= 1) is suppressed iff digit_reg[j] == 0 for all j in i..N_DIG-1. Digit 0 is never suppressed. A suppressed digit keeps an_n all 1 and dp_n = 1 for its slot, but slot timing is unchanged.
- en = 0:
  - cnt, idx and state hold; an_n all 1; dp_n = 1; frame_tick = 0.
  - On en returning to 1, the scan resumes from the held cnt/idx.
- Widths: cnt is clog2(PRESCALE) bits, no overflow beyond PRESCALE-1; idx never reaches N_DIG.

Test Plan:
- Reset/idle: N_DIG=4, PRESCALE=8, BLANK_CYCLES=2, en=1. Hold rst_n=0 for 3 clocks -> an_n=4'b1111, dp_n=1, bcd_out=0, frame_tick=0. Release -> cycles 0-1 an_n=1111; cycles 2-7 an_n=1110.
- Scan order: write digits 3..0 = 4,3,2,1, run 40 clocks. Each 8-cycle slot shows the pattern 1111,1111 then six cycles of the one-cold value, with one-cold in order 1110 (bcd 1), 1101 (2), 1011 (3), 0111 (4), then back to 1110. frame_tick high only at cycle 31.
- Leading zeros: digits = 0,0,5,0 (3..0), lz_blank=1 -> slots 3 and 2 keep an_n=1111; slot 1 shows 5; slot 0 shows 0 (1110). With lz_blank=0, all four digits are enabled.
- Mid-slot write and decimal point: during SHOW of idx=1, write wr_addr=1, wr_data=9 -> bcd_out=9 the next cycle, an_n stays 1101, slot length stays 8. With dp_mask=4'b0010, dp_n=0 only in SHOW of slot 1.
- Enable and reset mid-operation: drop en at cnt=5 of slot 2 for 10 clocks -> an_n=1111 and idx=2 hold; resume finishes the remaining 3 cycles. Then assert rst_n=0 in slot 3 -> next edge idx=0, an_n=1111, digit_regs=0.
